feature_lane_streamer: RTL and testbench

FEATURE_LANE_STREAMER -- requirements
Module: feature_lane_streamer

---
 rtl/feature_lane_streamer.sv | 118 +++++++++++
 tb/tb_feature_lane_streamer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/feature_lane_streamer.sv
// Captures a whole feature frame in one cycle, then streams it out LANES features per beat.
// Optional FEATURE_CHECKSUM_EN adds o_checksum, the signed frame sum presented on the last beat.
module feature_lane_streamer #(
  parameter int DATA_WIDTH     = 8,
  parameter int FEATURE_LENGTH = 300,
  parameter int LANES          = 8,
  localparam int BEATS         = (FEATURE_LENGTH + LANES - 1) / LANES,
  localparam int IDX_W         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [FEATURE_LENGTH*DATA_WIDTH-1:0] i_features,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [LANES*DATA_WIDTH-1:0]        o_data,
  output logic [LANES-1:0]                   o_keep,
  output logic                               o_last,
`ifdef FEATURE_CHECKSUM_EN
  output logic signed [DATA_WIDTH+$clog2(FEATURE_LENGTH):0] o_checksum,
`endif
  output logic [IDX_W-1:0]                   o_beat_idx
);

  localparam int LAST_LANES = FEATURE_LENGTH - (BEATS - 1) * LANES;
  localparam logic [LANES-1:0] LAST_KEEP = {LANES{1'b1}} >> (LANES - LAST_LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [IDX_W-1:0]                r_beat;
  logic [LANES*DATA_WIDTH-1:0]     r_buf [BEATS];
  logic [BEATS*LANES*DATA_WIDTH-1:0] w_padded;
  logic [LANES*DATA_WIDTH-1:0]     w_cur;
  logic                            w_stream;
  logic                            w_last;
  logic                            w_hs;
  logic                            w_capture;

  assign w_stream  = (r_state == STREAM);
  assign w_last    = w_stream && (r_beat == LAST_IDX);
  assign w_hs      = w_stream && i_ready;
  assign w_capture = (r_state == IDLE) && i_valid;
  assign w_cur     = r_buf[r_beat];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_valid) w_next = STREAM;
      STREAM:  if (w_hs && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture)
        r_beat <= '0;
      else if (w_hs && !w_last)
        r_beat <= r_beat + 1'b1;
    end
  end

  // Pad lanes past the frame end with zeros so partial last beats need no masking.
  always_comb begin
    w_padded = '0;
    w_padded[FEATURE_LENGTH*DATA_WIDTH-1:0] = i_features;
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int unsigned b = 0; b < BEATS; b++)
        r_buf[b] <= w_padded[b*LANES*DATA_WIDTH +: LANES*DATA_WIDTH];
    end
  end

  always_comb begin
    o_ready    = (r_state == IDLE);
    o_valid    = w_stream;
    o_last     = w_last;
    o_beat_idx = w_stream ? r_beat : '0;
    o_data     = w_stream ? w_cur : '0;
    o_keep     = !w_stream ? '0 : (w_last ? LAST_KEEP : '1);
  end

`ifdef FEATURE_CHECKSUM_EN
  localparam int CS_W = DATA_WIDTH + $clog2(FEATURE_LENGTH) + 1;

  logic signed [CS_W-1:0] r_acc;
  logic signed [CS_W-1:0] w_beat_sum;

  always_comb begin
    w_beat_sum = '0;
    for (int unsigned k = 0; k < LANES; k++)
      w_beat_sum = w_beat_sum + CS_W'($signed(w_cur[k*DATA_WIDTH +: DATA_WIDTH]));
  end

  // Earlier beats are accumulated on handshake; the last beat is folded in combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_acc <= '0;
    else if (w_capture)
      r_acc <= '0;
    else if (w_hs && !w_last)
      r_acc <= r_acc + w_beat_sum;
  end

  assign o_checksum = w_last ? (r_acc + w_beat_sum) : '0;
`endif

endmodule

// File: tb/tb_feature_lane_streamer.sv
// Directed-sequence bench with randomized frames, checked against an array-based frame model.
module tb_feature_lane_streamer;

  localparam int DW    = 8;
  localparam int FL    = 300;
  localparam int LN    = 8;
  localparam int BEATS = (FL + LN - 1) / LN;
  localparam int FL2   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              i_valid, i_ready, o_ready, o_valid, o_last;
  logic [FL*DW-1:0]  i_features;
  logic [LN*DW-1:0]  o_data;
  logic [LN-1:0]     o_keep;
  logic [5:0]        o_beat_idx;

  logic              f_ivalid, f_iready, f_ready, f_valid, f_last;
  logic [FL2*DW-1:0] f_features;
  logic [LN*DW-1:0]  f_data;
  logic [LN-1:0]     f_keep;
  logic [0:0]        f_idx;

`ifdef FEATURE_CHECKSUM_EN
  logic signed [17:0] o_checksum;
  logic signed [12:0] f_checksum;
`endif

  feature_lane_streamer #(.DATA_WIDTH(DW), .FEATURE_LENGTH(FL), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_features(i_features),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_keep(o_keep), .o_last(o_last),
`ifdef FEATURE_CHECKSUM_EN
    .o_checksum(o_checksum),
`endif
    .o_beat_idx(o_beat_idx)
  );

  feature_lane_streamer #(.DATA_WIDTH(DW), .FEATURE_LENGTH(FL2), .LANES(LN)) u_fit (
    .clk(clk), .rst(rst), .i_valid(f_ivalid), .o_ready(f_ready), .i_features(f_features),
    .o_valid(f_valid), .i_ready(f_iready), .o_data(f_data), .o_keep(f_keep), .o_last(f_last),
`ifdef FEATURE_CHECKSUM_EN
    .o_checksum(f_checksum),
`endif
    .o_beat_idx(f_idx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] cur [FL];
  logic [DW-1:0] nxt [FL];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [LN*DW-1:0] exp_data(input int b);
    logic [LN*DW-1:0] d = '0;
    for (int k = 0; k < LN; k++)
      if (b * LN + k < FL) d[k*DW +: DW] = cur[b*LN + k];
    return d;
  endfunction

  function automatic logic [LN-1:0] exp_keep(input int b);
    logic [LN-1:0] m = '0;
    for (int k = 0; k < LN; k++)
      if (b * LN + k < FL) m[k] = 1'b1;
    return m;
  endfunction

  function automatic int exp_sum();
    int s = 0;
    for (int g = 0; g < FL; g++) s += int'($signed(cur[g]));
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic use_nxt);
    for (int g = 0; g < FL; g++)
      i_features[g*DW +: DW] = use_nxt ? nxt[g] : cur[g];
  endtask

  task automatic capture();
    i_valid = 1'b1;
    drive_frame(1'b0);
    chk("cap_ready", 64'(o_ready), 64'd1);
    step();
    i_valid = 1'b0;
  endtask

  task automatic rand_frame();
    for (int g = 0; g < FL; g++) cur[g] = DW'($urandom);
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready
  task automatic stream(input int mode, input int inject_at, input int rst_at);
    int   b   = 0;
    int   hs  = 0;
    int   cyc = 0;
    logic rdy;
    while (b < BEATS && cyc < 1000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_ready = rdy;
      if (b == inject_at) begin
        i_valid = 1'b1;
        drive_frame(1'b1);
      end
      if (b == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(o_valid), 64'd0);
        chk("rst_mid_ready", 64'(o_ready), 64'd1);
        chk("rst_mid_data",  64'(o_data),  64'd0);
        chk("rst_mid_keep",  64'(o_keep),  64'd0);
        chk("rst_mid_last",  64'(o_last),  64'd0);
        chk("rst_mid_idx",   64'(o_beat_idx), 64'd0);
        step();
        rst = 1'b0;
        return;
      end
      chk($sformatf("valid b%0d", b), 64'(o_valid), 64'd1);
      chk($sformatf("ready b%0d", b), 64'(o_ready), 64'd0);
      chk($sformatf("idx b%0d", b),   64'(o_beat_idx), 64'(b));
      chk($sformatf("data b%0d", b),  64'(o_data), 64'(exp_data(b)));
      chk($sformatf("keep b%0d", b),  64'(o_keep), 64'(exp_keep(b)));
      chk($sformatf("last b%0d", b),  64'(o_last), 64'(b == BEATS - 1));
`ifdef FEATURE_CHECKSUM_EN
      chk($sformatf("csum b%0d", b), 64'(o_checksum),
          (b == BEATS - 1) ? 64'(longint'(exp_sum())) : 64'd0);
`endif
      step();
      cyc++;
      if (rdy) begin
        b++;
        hs++;
      end
    end
    chk("handshakes", 64'(hs), 64'(BEATS));
    chk("end_ready", 64'(o_ready), 64'd1);
    chk("end_valid", 64'(o_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_features = '0;
    f_ivalid = 1'b0; f_iready = 1'b0; f_features = '0;
    repeat (2) step();
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data",  64'(o_data),  64'd0);
    chk("rst_keep",  64'(o_keep),  64'd0);
    chk("rst_last",  64'(o_last),  64'd0);
    chk("rst_idx",   64'(o_beat_idx), 64'd0);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_hold_ready", 64'(o_ready), 64'd1);
    chk("idle_hold_valid", 64'(o_valid), 64'd0);

    for (int g = 0; g < FL; g++) cur[g] = DW'(g % 128);
    capture();
    stream(0, -1, -1);

    rand_frame();
    capture();
    stream(1, -1, -1);

    rand_frame();
    capture();
    stream(2, -1, -1);

    rand_frame();
    for (int g = 0; g < FL; g++) nxt[g] = DW'($urandom);
    capture();
    stream(0, 10, -1);
    cur = nxt;
    capture();
    stream(2, -1, -1);

    rand_frame();
    capture();
    stream(0, -1, 20);
    chk("post_rst_ready", 64'(o_ready), 64'd1);
    rand_frame();
    capture();
    stream(0, -1, -1);

    for (int g = 0; g < FL; g++) cur[g] = 8'hFF;
    capture();
    stream(0, -1, -1);
    for (int g = 0; g < FL; g++) cur[g] = 8'd127;
    capture();
    stream(1, -1, -1);

    for (int g = 0; g < FL2; g++) f_features[g*DW +: DW] = DW'($urandom);
    f_ivalid = 1'b1;
    f_iready = 1'b1;
    chk("fit_cap_ready", 64'(f_ready), 64'd1);
    step();
    f_ivalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("fit_valid b%0d", b), 64'(f_valid), 64'd1);
      chk($sformatf("fit_idx b%0d", b),   64'(f_idx), 64'(b));
      chk($sformatf("fit_keep b%0d", b),  64'(f_keep), 64'hFF);
      chk($sformatf("fit_last b%0d", b),  64'(f_last), 64'(b == 1));
      chk($sformatf("fit_data b%0d", b),  64'(f_data), 64'(f_features[b*LN*DW +: LN*DW]));
      step();
    end
    chk("fit_end_ready", 64'(f_ready), 64'd1);
    chk("fit_end_valid", 64'(f_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
